// File: rtl/riscv_v_csr_wr_pipe.sv
// Vector CSR write pipeline: fixed-priority arbitration in ID, winner-data select in EXE,
// per-CSR write enables/data at WB after ID2EXE_LAT+EXE2WB_LAT cycles; stall holds, flush kills.
module riscv_v_csr_wr_pipe #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_CSR    = 6,
  parameter int DATA_W     = 32,
  parameter int ID2EXE_LAT = 1,
  parameter int EXE2WB_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [NUM_SRC*NUM_CSR-1:0]  src_wr_id,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data_exe,
  output logic [NUM_CSR-1:0]          csr_wr_en_wb,
  output logic [NUM_CSR*DATA_W-1:0]   csr_wr_data_wb,
  output logic [NUM_CSR-1:0]          csr_pending,
  output logic                        conflict_id,
  output logic                        conflict_sticky
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_CSR-1:0]                        vld_id;
  logic [NUM_CSR-1:0][IDX_W-1:0]             win_id;
  logic [NUM_CSR-1:0]                        multi_id;

  logic [ID2EXE_LAT-1:0][NUM_CSR-1:0]             ie_vld;
  logic [ID2EXE_LAT-1:0][NUM_CSR-1:0][IDX_W-1:0]  ie_idx;
  logic [EXE2WB_LAT-1:0][NUM_CSR-1:0]             wb_vld;
  logic [EXE2WB_LAT-1:0][NUM_CSR-1:0][DATA_W-1:0] wb_dat;

  logic [NUM_CSR-1:0]                        exe_vld;
  logic [NUM_CSR-1:0][DATA_W-1:0]            exe_data;
  logic [NUM_CSR-1:0]                        pend;

  // Scan from the lowest-priority source down so source 0 is written last and wins.
  always_comb begin
    vld_id   = '0;
    win_id   = '0;
    multi_id = '0;
    for (int c = 0; c < NUM_CSR; c++) begin
      for (int s = NUM_SRC - 1; s >= 0; s--) begin
        if (src_wr_id[s*NUM_CSR + c]) begin
          if (vld_id[c]) multi_id[c] = 1'b1;
          vld_id[c] = 1'b1;
          win_id[c] = IDX_W'(s);
        end
      end
    end
  end

  assign conflict_id = |multi_id;

  assign exe_vld = ie_vld[ID2EXE_LAT-1];

  always_comb begin
    exe_data = '0;
    for (int c = 0; c < NUM_CSR; c++) begin
      if (exe_vld[c]) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (ie_idx[ID2EXE_LAT-1][c] == IDX_W'(s)) exe_data[c] = src_data_exe[s*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_vld <= '0;
      ie_idx <= '0;
    end else if (flush || !stall) begin
      ie_vld[0] <= flush ? '0 : vld_id;
      ie_idx[0] <= win_id;
      for (int k = 1; k < ID2EXE_LAT; k++) begin
        ie_vld[k] <= flush ? '0 : ie_vld[k-1];
        ie_idx[k] <= ie_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld <= '0;
      wb_dat <= '0;
    end else if (flush || !stall) begin
      wb_vld[0] <= flush ? '0 : exe_vld;
      wb_dat[0] <= exe_data;
      for (int k = 1; k < EXE2WB_LAT; k++) begin
        wb_vld[k] <= flush ? '0 : wb_vld[k-1];
        wb_dat[k] <= wb_dat[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_sticky <= 1'b0;
    else if (conflict_id && !stall) conflict_sticky <= 1'b1;
  end

  always_comb begin
    pend = '0;
    for (int k = 0; k < ID2EXE_LAT; k++) pend = pend | ie_vld[k];
    for (int k = 0; k < EXE2WB_LAT; k++) pend = pend | wb_vld[k];
  end

  assign csr_pending    = pend;
  assign csr_wr_en_wb   = wb_vld[EXE2WB_LAT-1];
  assign csr_wr_data_wb = wb_dat[EXE2WB_LAT-1];

endmodule

// File: doc/riscv_v_csr_wr_pipe.md
# riscv_v_csr_wr_pipe

Parametrised vector CSR write pipeline that sits between instruction decode and the vector CSR file. It collects per-CSR write requests from NUM_SRC sources in ID and resolves same-cycle conflicts by fixed priority instead of failing. It carries the winning request through configurable ID→EXE and EXE→WB latencies, samples the winner's data in EXE, and presents per-CSR write enables and data at WB. It also exports a per-CSR pending mask for read-after-write hazard detection, plus conflict reporting.

## Interface
Parameters:
- NUM_SRC, 2: number of write sources; index 0 has highest priority.
- NUM_CSR, 6: number of CSRs handled; 0..5 = vsstatus, vtype, vl, vstart, vxrm, vxsat.
- DATA_W, 32: write data width.
- ID2EXE_LAT, 1: register stages from ID to EXE; must be ≥1.
- EXE2WB_LAT, 1: register stages from EXE to WB; must be ≥1.

Ports:
- clk  in  1  clock; the block uses a single clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  holds all stages while high.
- flush  in  1  synchronous kill of all in-flight writes; takes priority over stall.
- src_wr_id  in  NUM_SRC*NUM_CSR  write request in ID; bit s*NUM_CSR+c means source s writes CSR c.
- src_data_exe  in  NUM_SRC*DATA_W  source s write data, valid in EXE, at [s*DATA_W +: DATA_W].
- csr_wr_en_wb  out  NUM_CSR  per-CSR write enable at WB.
- csr_wr_data_wb  out  NUM_CSR*DATA_W  CSR c data at [c*DATA_W +: DATA_W].
- csr_pending  out  NUM_CSR  CSR c has a write in flight in any stage register.
- conflict_id  out  1  combinational: more than one source requests the same CSR this cycle.
- conflict_sticky  out  1  set by any conflict_id seen while not stalled; cleared only by rst.

## Operation
- ID arbitration, per CSR c:
  - valid_id[c] = OR over s of the request bits for c.
  - The winner is the lowest requesting s; it is encoded in $clog2(NUM_SRC) bits, or 1 bit when NUM_SRC=1.
  - Losers are dropped silently. conflict_id flags the collision.
- ID→EXE pipe: ID2EXE_LAT stages, each holding {valid, winner index} per CSR.
- EXE data select:
  - exe_data[c] = src_data_exe of the stored winner when the EXE valid is set, else all-zero.
  - Operand data must never leak into a non-valid slot.
- EXE→WB pipe: EXE2WB_LAT stages, each holding {valid, data} per CSR. The last stage drives csr_wr_en_wb and csr_wr_data_wb.
- Stage update rule, applied to every register in priority order:
  - rst: all valids, indices and data go to 0.
  - flush: all valids go to 0; data and indices may update.
  - stall: hold.
  - otherwise: shift.
- csr_pending[c] = OR of valid[c] over every ID→EXE and EXE→WB stage register, WB output included. The ID input is excluded.
- conflict_sticky: set on posedge when conflict_id=1 and stall=0.
- Stall with csr_wr_en_wb=1 keeps the enable and data asserted. The CSR file rewrites the same value, which is idempotent and legal.
- Requests presented in ID while stall=1 are not captured. The upstream stage must hold them.

## Timing
- Reset values:
  - csr_wr_en_wb = 0, csr_wr_data_wb = 0, csr_pending = 0, conflict_sticky = 0.
  - conflict_id follows src_wr_id combinationally.
- Latency with no stall, requests captured at edge t:
  - EXE data is sampled during the cycle after ID2EXE_LAT edges.
  - csr_wr_en_wb is high ID2EXE_LAT+EXE2WB_LAT cycles after the ID cycle; with defaults, ID at cycle 0 gives WB at cycle 2.
  - Each stall cycle adds one cycle.
- csr_pending[c] rises on the first edge after the request and falls on the edge the WB slot retires.
- Throughput: one write per CSR per cycle. Back-to-back writes to the same CSR each reach WB in order.
- Flush asserted on edge t clears all slots at t. The next cycle shows csr_wr_en_wb=0 and csr_pending=0. A request present in ID during that flush cycle is discarded.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Test plan
- Defaults; source 1 requests vl (c=2) in cycle 0; src_data_exe[1]=0x10 in cycle 1 → csr_wr_en_wb=6'b000100 and data[2]=0x10 in cycle 2; csr_pending[2] is high in cycles 1-2.
- Sources 0 and 1 both request vtype in cycle 0; data 0xA (s0) and 0xB (s1) → conflict_id=1 in cycle 0; WB vtype=0xA; conflict_sticky=1 from cycle 1 until rst.
- Request vxrm in cycle 0, stall high in cycles 1-2 → WB enable appears in cycle 4 with correct data; no enable in cycles 2-3.
- Request vstart in cycle 0, flush in cycle 1 (also with stall high) → csr_wr_en_wb never asserts; csr_pending=0 from cycle 2.
- NUM_SRC=3, ID2EXE_LAT=2, EXE2WB_LAT=3; source 2 writes vl in consecutive cycles with data 1, 2, 3 → WB enables in cycles 5, 6, 7 with data 1, 2, 3; non-written CSR data stays 0.
- rst pulsed asynchronously mid-pipe with writes in flight → all outputs go to 0 before the next edge.
